// File: rtl/store_buffer_if.sv
// Bundles the MEM-stage request side and the data-memory port side of the store buffer.
// The DUT connects through the slave modport; the pipeline/bench drives through the master modport.
interface store_buffer_if #(parameter int PTR_W = 2);
  logic              st_req;
  logic [31:0]       st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              ld_req;
  logic [31:0]       ld_addr;
  logic [1:0]        ld_size;
  logic              stall;
  logic              misaligned;
  logic              full;
  logic              empty;
  logic [PTR_W:0]    count;
  logic              mem_w_en;
  logic              mem_r_en;
  logic [31:0]       mem_address;
  logic [31:0]       mem_w_data;
  logic [1:0]        mem_read_command;
  logic [1:0]        mem_write_command;

  modport master (
    output st_req, st_addr, st_data, st_size, ld_req, ld_addr, ld_size,
    input  stall, misaligned, full, empty, count,
           mem_w_en, mem_r_en, mem_address, mem_w_data, mem_read_command, mem_write_command
  );

  modport slave (
    input  st_req, st_addr, st_data, st_size, ld_req, ld_addr, ld_size,
    output stall, misaligned, full, empty, count,
           mem_w_en, mem_r_en, mem_address, mem_w_data, mem_read_command, mem_write_command
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM stage and data memory; drains one store per cycle
// whenever a non-conflicting load is not using the memory port.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;

  logic legal;
  logic full;
  logic empty;
  logic entry_hit;
  logic conflict;
  logic load_issue;
  logic enq;
  logic drain;

  always_comb begin
    legal = 1'b0;
    case (bus.st_size)
      2'd0:    legal = (bus.st_addr[1:0] == 2'b00);
      2'd1:    legal = ~bus.st_addr[0];
      2'd2:    legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    entry_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][31:2] == bus.ld_addr[31:2]))
        entry_hit = 1'b1;
    end
  end

  // A legal store in the same cycle to the loaded word also blocks the load.
  assign full       = (count_q == DEPTH_CNT);
  assign empty      = (count_q == '0);
  assign conflict   = bus.ld_req &
                      (entry_hit | (bus.st_req & legal & (bus.st_addr[31:2] == bus.ld_addr[31:2])));
  assign load_issue = bus.ld_req & ~conflict;
  assign enq        = bus.st_req & legal & ~full;
  assign drain      = ~empty & ~load_issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        addr_q[tail_q]  <= bus.st_addr;
        data_q[tail_q]  <= bus.st_data;
        size_q[tail_q]  <= bus.st_size;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({enq, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // While reset is held every output is quiet except empty.
  always_comb begin
    bus.stall             = 1'b0;
    bus.misaligned        = 1'b0;
    bus.full              = 1'b0;
    bus.empty             = 1'b1;
    bus.count             = '0;
    bus.mem_w_en          = 1'b0;
    bus.mem_r_en          = 1'b0;
    bus.mem_address       = '0;
    bus.mem_w_data        = '0;
    bus.mem_read_command  = '0;
    bus.mem_write_command = '0;
    if (!rst) begin
      bus.stall      = (bus.st_req & legal & full) | conflict;
      bus.misaligned = bus.st_req & ~legal;
      bus.full       = full;
      bus.empty      = empty;
      bus.count      = count_q;
      if (load_issue) begin
        bus.mem_r_en         = 1'b1;
        bus.mem_address      = bus.ld_addr;
        bus.mem_read_command = bus.ld_size;
      end else if (drain) begin
        bus.mem_w_en          = 1'b1;
        bus.mem_address       = addr_q[head_q];
        bus.mem_w_data        = data_q[head_q];
        bus.mem_write_command = size_q[head_q];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: one task per scenario, inputs driven
// on the falling edge and outputs checked 1ns later, well away from the rising edge.
module tb_store_buffer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  store_buffer_if #(.PTR_W(2)) sb ();

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    sb.st_req  = 1'b0;
    sb.st_addr = '0;
    sb.st_data = '0;
    sb.st_size = '0;
    sb.ld_req  = 1'b0;
    sb.ld_addr = '0;
    sb.ld_size = '0;
  endtask

  task automatic set_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    sb.st_req  = 1'b1;
    sb.st_addr = addr;
    sb.st_data = data;
    sb.st_size = size;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    set_idle();
    set_store(32'h6, 32'h1, 2'd3);
    sb.ld_req  = 1'b1;
    sb.ld_addr = 32'h40;
    #1;
    checks++; if (sb.misaligned !== 1'b0) begin errors++; $display("[TB] FAIL rst_misaligned actual=%b required=0", sb.misaligned); end
    checks++; if (sb.mem_r_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_r_en actual=%b required=0", sb.mem_r_en); end
    checks++; if (sb.mem_address !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_address actual=%h required=0", sb.mem_address); end
    checks++; if (sb.empty !== 1'b1) begin errors++; $display("[TB] FAIL rst_empty actual=%b required=1", sb.empty); end
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    #1;
    checks++; if (sb.count !== 3'd0) begin errors++; $display("[TB] FAIL post_rst_count actual=%0d required=0", sb.count); end
    checks++; if (sb.empty !== 1'b1 || sb.full !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_flags actual=%b%b required=10", sb.empty, sb.full); end
    checks++; if (sb.mem_w_en !== 1'b0 || sb.stall !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_idle actual=%b%b required=00", sb.mem_w_en, sb.stall); end
  endtask

  task automatic test_single_store();
    @(negedge clk);
    set_store(32'h10, 32'hDEADBEEF, 2'd0);
    #1;
    checks++; if (sb.mem_w_en !== 1'b0 || sb.empty !== 1'b1) begin errors++; $display("[TB] FAIL single_c1 actual=%b%b required=01", sb.mem_w_en, sb.empty); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (sb.mem_w_en !== 1'b1) begin errors++; $display("[TB] FAIL single_w_en actual=%b required=1", sb.mem_w_en); end
    checks++; if (sb.mem_address !== 32'h10) begin errors++; $display("[TB] FAIL single_addr actual=%h required=00000010", sb.mem_address); end
    checks++; if (sb.mem_w_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_data actual=%h required=deadbeef", sb.mem_w_data); end
    checks++; if (sb.mem_write_command !== 2'd0 || sb.count !== 3'd1) begin errors++; $display("[TB] FAIL single_cmd_count actual=%0d/%0d required=0/1", sb.mem_write_command, sb.count); end
    @(negedge clk);
    #1;
    checks++; if (sb.empty !== 1'b1 || sb.mem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL single_c3 actual=%b%b required=10", sb.empty, sb.mem_w_en); end
  endtask

  task automatic test_full_and_order();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_idle();
      sb.ld_req  = 1'b1;
      sb.ld_addr = 32'h100;
      set_store(32'(4 * i), 32'h1000 + 32'(i), 2'd0);
      #1;
      checks++; if (sb.mem_r_en !== 1'b1 || sb.mem_w_en !== 1'b0 || sb.mem_address !== 32'h100) begin errors++; $display("[TB] FAIL full_load%0d actual=%b%b_%h required=10_00000100", i, sb.mem_r_en, sb.mem_w_en, sb.mem_address); end
      checks++; if (sb.count !== 3'(i < 4 ? i : 4)) begin errors++; $display("[TB] FAIL full_count%0d actual=%0d required=%0d", i, sb.count, (i < 4 ? i : 4)); end
      checks++; if (sb.stall !== (i == 4)) begin errors++; $display("[TB] FAIL full_stall%0d actual=%b required=%b", i, sb.stall, (i == 4)); end
    end
    checks++; if (sb.full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag actual=%b required=1", sb.full); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_idle();
      #1;
      checks++; if (sb.mem_w_en !== 1'b1 || sb.mem_address !== 32'(4 * i) || sb.mem_w_data !== 32'h1000 + 32'(i)) begin errors++; $display("[TB] FAIL drain_order%0d actual=%b_%h_%h required=1_%h_%h", i, sb.mem_w_en, sb.mem_address, sb.mem_w_data, 4 * i, 32'h1000 + 32'(i)); end
      checks++; if (sb.count !== 3'(4 - i)) begin errors++; $display("[TB] FAIL drain_count%0d actual=%0d required=%0d", i, sb.count, 4 - i); end
    end
    @(negedge clk);
    #1;
    checks++; if (sb.empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty actual=%b required=1", sb.empty); end
  endtask

  task automatic test_load_conflict();
    @(negedge clk);
    set_idle();
    set_store(32'h21, 32'h000000AB, 2'd2);
    @(negedge clk);
    set_idle();
    sb.ld_req  = 1'b1;
    sb.ld_addr = 32'h20;
    sb.ld_size = 2'd0;
    #1;
    checks++; if (sb.stall !== 1'b1 || sb.mem_r_en !== 1'b0) begin errors++; $display("[TB] FAIL conflict_stall actual=%b%b required=10", sb.stall, sb.mem_r_en); end
    checks++; if (sb.mem_w_en !== 1'b1 || sb.mem_address !== 32'h21 || sb.mem_write_command !== 2'd2) begin errors++; $display("[TB] FAIL conflict_drain actual=%b_%h_%0d required=1_00000021_2", sb.mem_w_en, sb.mem_address, sb.mem_write_command); end
    @(negedge clk);
    #1;
    checks++; if (sb.stall !== 1'b0 || sb.mem_r_en !== 1'b1 || sb.mem_address !== 32'h20) begin errors++; $display("[TB] FAIL conflict_release actual=%b%b_%h required=01_00000020", sb.stall, sb.mem_r_en, sb.mem_address); end
    @(negedge clk);
    set_idle();
    sb.ld_req  = 1'b1;
    sb.ld_addr = 32'h50;
    set_store(32'h52, 32'h7, 2'd1);
    #1;
    checks++; if (sb.stall !== 1'b1 || sb.mem_r_en !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_conflict actual=%b%b required=10", sb.stall, sb.mem_r_en); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (sb.mem_w_en !== 1'b1 || sb.mem_address !== 32'h52) begin errors++; $display("[TB] FAIL same_cycle_drain actual=%b_%h required=1_00000052", sb.mem_w_en, sb.mem_address); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    set_idle();
    set_store(32'h6, 32'h1, 2'd0);
    #1;
    checks++; if (sb.misaligned !== 1'b1 || sb.stall !== 1'b0) begin errors++; $display("[TB] FAIL mis_sw actual=%b%b required=10", sb.misaligned, sb.stall); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (sb.misaligned !== 1'b0 || sb.count !== 3'd0) begin errors++; $display("[TB] FAIL mis_sw_after actual=%b_%0d required=0_0", sb.misaligned, sb.count); end
    @(negedge clk);
    set_store(32'h3, 32'h2, 2'd1);
    #1;
    checks++; if (sb.misaligned !== 1'b1) begin errors++; $display("[TB] FAIL mis_sh actual=%b required=1", sb.misaligned); end
    @(negedge clk);
    set_store(32'h8, 32'h3, 2'd3);
    #1;
    checks++; if (sb.misaligned !== 1'b1) begin errors++; $display("[TB] FAIL mis_size3 actual=%b required=1", sb.misaligned); end
    @(negedge clk);
    set_store(32'h2, 32'h1234, 2'd1);
    #1;
    checks++; if (sb.misaligned !== 1'b0 || sb.count !== 3'd0) begin errors++; $display("[TB] FAIL sh_ok actual=%b_%0d required=0_0", sb.misaligned, sb.count); end
    @(negedge clk);
    set_idle();
    #1;
    checks++; if (sb.mem_w_en !== 1'b1 || sb.mem_address !== 32'h2 || sb.mem_write_command !== 2'd1 || sb.mem_w_data !== 32'h1234) begin errors++; $display("[TB] FAIL sh_drain actual=%b_%h_%0d_%h required=1_00000002_1_00001234", sb.mem_w_en, sb.mem_address, sb.mem_write_command, sb.mem_w_data); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_idle();
      if (i < 10) set_store(32'h40 + 32'(4 * i), 32'(i), 2'd0);
      #1;
      checks++; if (sb.count !== 3'(i == 0 ? 0 : 1)) begin errors++; $display("[TB] FAIL b2b_count%0d actual=%0d required=%0d", i, sb.count, (i == 0 ? 0 : 1)); end
      if (i > 0) begin
        checks++; if (sb.mem_w_en !== 1'b1 || sb.mem_address !== 32'h40 + 32'(4 * (i - 1))) begin errors++; $display("[TB] FAIL b2b_addr%0d actual=%b_%h required=1_%h", i, sb.mem_w_en, sb.mem_address, 32'h40 + 32'(4 * (i - 1))); end
      end
    end
    @(negedge clk);
    #1;
    checks++; if (sb.empty !== 1'b1 || sb.mem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end actual=%b%b required=10", sb.empty, sb.mem_w_en); end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle();
      sb.ld_req  = 1'b1;
      sb.ld_addr = 32'h200;
      set_store(32'h300 + 32'(4 * i), 32'hF0 + 32'(i), 2'd0);
    end
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    #1;
    checks++; if (sb.mem_w_en !== 1'b0 || sb.empty !== 1'b1 || sb.count !== 3'd0) begin errors++; $display("[TB] FAIL rst_mid_forced actual=%b%b_%0d required=01_0", sb.mem_w_en, sb.empty, sb.count); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (sb.count !== 3'd0 || sb.empty !== 1'b1 || sb.mem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_after actual=%0d_%b%b required=0_10", sb.count, sb.empty, sb.mem_w_en); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++; if (sb.mem_w_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_nowrite%0d actual=%b required=0", i, sb.mem_w_en); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    set_idle();
    test_reset();
    test_single_store();
    test_full_and_order();
    test_load_conflict();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
